// File: rtl/period_meter.sv
`default_nettype none
// ============================================================================
// Module   : period_meter
// Brief    : Times consecutive rising edges of an asynchronous square wave in
//            clk cycles; optional glitch filter via PERIOD_METER_GLITCH_FILTER_EN.
// Revision : 1.0
// ============================================================================
module period_meter #(
    parameter  int MAX_PERIOD = 65535,
    parameter  int FILTER_LEN = 4,
    localparam int W          = $clog2(MAX_PERIOD + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sq_in,
    output logic [W-1:0] period,
    output logic         period_valid,
    output logic         timeout
);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_MEASURE = 1'b1;

    if (FILTER_LEN < 1 || MAX_PERIOD < 2) begin : g_param_check
        $error("period_meter: requires FILTER_LEN >= 1 and MAX_PERIOD >= 2");
    end

    logic         r_sync1;
    logic         r_sync2;
    logic         w_lvl;
    logic         r_lvl_d;
    logic         w_edge;
    logic [0:0]   r_state;
    logic [0:0]   w_state_nxt;
    logic [W-1:0] r_cnt;
    logic [W-1:0] r_period;
    logic         r_period_valid;
    logic         r_timeout;
    logic         w_at_max;
    logic         w_load_period;
    logic         w_set_timeout;
    logic         w_cnt_inc;

    // Reset to 1 so a line held high through reset never looks like a rising edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_lvl_d <= 1'b1;
        end else begin
            r_sync1 <= sq_in;
            r_sync2 <= r_sync1;
            r_lvl_d <= w_lvl;
        end
    end

`ifdef PERIOD_METER_GLITCH_FILTER_EN
    localparam int FW = $clog2(FILTER_LEN + 1);

    logic [FW-1:0] r_flt_cnt;
    logic          r_flt_lvl;

    // Level follows sync only after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_flt_lvl <= 1'b1;
            r_flt_cnt <= '0;
        end else if (r_sync2 == r_flt_lvl) begin
            r_flt_cnt <= '0;
        end else if (r_flt_cnt == FW'(FILTER_LEN - 1)) begin
            r_flt_lvl <= r_sync2;
            r_flt_cnt <= '0;
        end else begin
            r_flt_cnt <= r_flt_cnt + FW'(1);
        end
    end

    assign w_lvl = r_flt_lvl;
`else
    assign w_lvl = r_sync2;
`endif

    assign w_edge   = w_lvl & ~r_lvl_d;
    assign w_at_max = (r_cnt == W'(MAX_PERIOD));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_edge)               w_state_nxt = S_MEASURE;
            S_MEASURE: if (!w_edge && w_at_max)  w_state_nxt = S_IDLE;
            default:                             w_state_nxt = S_IDLE;
        endcase
    end

    // An edge coinciding with cnt==MAX_PERIOD is a valid measurement, not a timeout.
    always_comb begin
        w_load_period = 1'b0;
        w_set_timeout = 1'b0;
        w_cnt_inc     = 1'b0;
        if (r_state == S_MEASURE) begin
            w_load_period = w_edge;
            w_set_timeout = !w_edge && w_at_max;
            w_cnt_inc     = !w_edge && !w_at_max;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt          <= '0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_period_valid <= w_load_period;
            if (w_edge) begin
                r_cnt <= W'(1);
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + W'(1);
            end
            if (w_load_period) begin
                r_period  <= r_cnt;
                r_timeout <= 1'b0;
            end else if (w_set_timeout) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign period       = r_period;
    assign period_valid = r_period_valid;
    assign timeout      = r_timeout;

endmodule
`default_nettype wire
